// File: rtl/merge_node_xl_if.sv
// Stream bundle for merge_node_xl: two record inputs, merged output and status.
// master drives the producer/consumer side, slave is the merge node itself.
interface merge_node_xl_if #(
  parameter int DATW = 64,
  parameter int CNTW = 32
);
  logic            MODE;
  logic [DATW-1:0] DIN0;
  logic [DATW-1:0] DIN1;
  logic            DIN0EN;
  logic            DIN1EN;
  logic            DIN0LAST;
  logic            DIN1LAST;
  logic            FUL0;
  logic            FUL1;
  logic            IN_FULL;
  logic [DATW-1:0] DOT;
  logic            DOTEN;
  logic            DOTLAST;
  logic [CNTW-1:0] CNT;
  logic            OVF;

  modport master (
    output MODE, DIN0, DIN1, DIN0EN, DIN1EN, DIN0LAST, DIN1LAST, IN_FULL,
    input  FUL0, FUL1, DOT, DOTEN, DOTLAST, CNT, OVF
  );

  modport slave (
    input  MODE, DIN0, DIN1, DIN0EN, DIN1EN, DIN0LAST, DIN1LAST, IN_FULL,
    output FUL0, FUL1, DOT, DOTEN, DOTLAST, CNT, OVF
  );
endinterface

// File: rtl/merge_node_xl.sv
// Two-input sorted-stream merge node with per-input FIFOs, run framing,
// asc/desc mode latched per run, back-pressure and a per-run record counter.
module merge_node_xl #(
  parameter int DATW     = 64,
  parameter int KEYW     = 32,
  parameter int FIFO_LOG = 2,
  parameter int CNTW     = 32
) (
  input logic            CLK,
  input logic            RST_X,
  merge_node_xl_if.slave bus
);

  localparam int DEPTH = 1 << FIFO_LOG;

  typedef logic [FIFO_LOG-1:0] ptr_t;
  typedef logic [FIFO_LOG:0]   occ_t;
  typedef enum logic [1:0] {
    ST_MERGE  = 2'd0,
    ST_DRAIN0 = 2'd1,
    ST_DRAIN1 = 2'd2
  } state_t;

  localparam occ_t OCC_MAX = occ_t'(DEPTH);
  localparam occ_t OCC_HI  = occ_t'(DEPTH - 1);

  // FIFO storage holds {last, data}; index 0/1 selects the input
  logic [DATW:0]   mem_r [2][DEPTH];
  ptr_t            wp_r [2];
  ptr_t            rp_r [2];
  occ_t            occ_r [2];
  occ_t            occ_nx_s [2];
  logic [DATW:0]   din_s [2];
  logic [DATW:0]   head_s [2];
  logic [KEYW-1:0] key_s [2];
  logic [1:0]      wen_s;
  logic [1:0]      vld_s;
  logic [1:0]      acc_s;
  logic [1:0]      drop_s;
  logic [1:0]      deq_s;
  logic [1:0]      ful_r;

  state_t          state_r;
  state_t          state_nx_s;
  logic            sel_s;
  logic            last_s;
  logic            deq_any_s;
  logic [DATW:0]   rec_s;
  logic            mode_r;
  logic            run_r;
  logic            ovf_r;
  logic [DATW-1:0] dot_r;
  logic            doten_r;
  logic            dotlast_r;
  logic [CNTW-1:0] cnt_r;

  assign din_s[0] = {bus.DIN0LAST, bus.DIN0};
  assign din_s[1] = {bus.DIN1LAST, bus.DIN1};
  assign wen_s    = {bus.DIN1EN, bus.DIN0EN};

  // FIFO head view
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      head_s[i] = mem_r[i][rp_r[i]];
      key_s[i]  = head_s[i][KEYW-1:0];
      vld_s[i]  = (occ_r[i] != '0);
    end
  end

  // Dequeue decision and next state; ties go to input 0
  always_comb begin
    state_nx_s = state_r;
    deq_s      = 2'b00;
    sel_s      = 1'b0;
    last_s     = 1'b0;
    case (state_r)
      ST_MERGE: begin
        sel_s = mode_r ? (key_s[1] > key_s[0]) : (key_s[1] < key_s[0]);
        if ((vld_s == 2'b11) && !bus.IN_FULL) begin
          deq_s = sel_s ? 2'b10 : 2'b01;
          if (head_s[sel_s][DATW]) begin
            state_nx_s = sel_s ? ST_DRAIN0 : ST_DRAIN1;
          end else begin
            state_nx_s = ST_MERGE;
          end
        end else begin
          state_nx_s = ST_MERGE;
        end
      end
      ST_DRAIN0: begin
        sel_s = 1'b0;
        if (vld_s[0] && !bus.IN_FULL) begin
          deq_s      = 2'b01;
          last_s     = head_s[0][DATW];
          state_nx_s = head_s[0][DATW] ? ST_MERGE : ST_DRAIN0;
        end else begin
          state_nx_s = ST_DRAIN0;
        end
      end
      ST_DRAIN1: begin
        sel_s = 1'b1;
        if (vld_s[1] && !bus.IN_FULL) begin
          deq_s      = 2'b10;
          last_s     = head_s[1][DATW];
          state_nx_s = head_s[1][DATW] ? ST_MERGE : ST_DRAIN1;
        end else begin
          state_nx_s = ST_DRAIN1;
        end
      end
      default: begin
        state_nx_s = ST_MERGE;
      end
    endcase
  end

  assign deq_any_s = |deq_s;
  assign rec_s     = head_s[sel_s];

  // A write at full is still taken when the same FIFO pops this cycle
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      acc_s[i]    = wen_s[i] & ((occ_r[i] != OCC_MAX) | deq_s[i]);
      drop_s[i]   = wen_s[i] & ~acc_s[i];
      occ_nx_s[i] = occ_r[i] + occ_t'(acc_s[i]) - occ_t'(deq_s[i]);
    end
  end

  // FIFO pointers, occupancy and registered almost-full
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      for (int i = 0; i < 2; i++) begin
        wp_r[i]  <= '0;
        rp_r[i]  <= '0;
        occ_r[i] <= '0;
      end
      ful_r <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        wp_r[i]  <= wp_r[i] + ptr_t'(acc_s[i]);
        rp_r[i]  <= rp_r[i] + ptr_t'(deq_s[i]);
        occ_r[i] <= occ_nx_s[i];
        ful_r[i] <= (occ_nx_s[i] >= OCC_HI);
      end
    end
  end

  // FIFO storage write port
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (acc_s[i]) begin
        mem_r[i][wp_r[i]] <= din_s[i];
      end
    end
  end

  // State, per-run mode latch, overflow flag and registered output stage
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_r   <= ST_MERGE;
      mode_r    <= 1'b0;
      run_r     <= 1'b0;
      ovf_r     <= 1'b0;
      dot_r     <= '0;
      doten_r   <= 1'b0;
      dotlast_r <= 1'b0;
      cnt_r     <= '0;
    end else begin
      state_r <= state_nx_s;
      if (!run_r && !deq_any_s) begin
        mode_r <= bus.MODE;
      end
      if (deq_any_s) begin
        run_r <= !last_s;
        dot_r <= rec_s[DATW-1:0];
      end
      ovf_r     <= ovf_r | (|drop_s);
      doten_r   <= deq_any_s;
      dotlast_r <= deq_any_s & last_s;
      // counter restarts once the run's closing record has been shown
      cnt_r     <= ((doten_r && dotlast_r) ? '0 : cnt_r) + {{(CNTW-1){1'b0}}, deq_any_s};
    end
  end

  assign bus.FUL0    = ful_r[0];
  assign bus.FUL1    = ful_r[1];
  assign bus.DOT     = dot_r;
  assign bus.DOTEN   = doten_r;
  assign bus.DOTLAST = dotlast_r;
  assign bus.CNT     = cnt_r;
  assign bus.OVF     = ovf_r;

endmodule

// File: tb/tb_merge_node_xl.sv
// Bench for merge_node_xl: queue-based reference model compared every cycle,
// directed scenarios pinned with literal sequences, then randomized traffic.
module tb_merge_node_xl;

  localparam int DATW = 64;
  localparam int KEYW = 32;
  localparam int FLOG = 2;
  localparam int CNTW = 32;
  localparam int D    = 1 << FLOG;

  logic clk;
  logic rst_n;

  merge_node_xl_if #(.DATW(DATW), .CNTW(CNTW)) bus ();

  merge_node_xl #(.DATW(DATW), .KEYW(KEYW), .FIFO_LOG(FLOG), .CNTW(CNTW)) dut (
    .CLK   (clk),
    .RST_X (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // reference model state
  logic [DATW:0]   q0[$];
  logic [DATW:0]   q1[$];
  int              done_in;
  bit              m_started;
  bit              m_mode;
  bit              m_ovf;
  logic [DATW-1:0] e_dot;
  bit              e_doten;
  bit              e_last;
  logic [CNTW-1:0] e_cnt;
  bit              e_ful0;
  bit              e_ful1;
  int              sel;
  bit              olast;
  logic [DATW:0]   rec;

  logic [DATW:0]   dut_log[$];
  logic [DATW:0]   m_log[$];
  int              dut_cnt[$];

  // model step per edge, then compare DUT outputs 1 time unit after the edge
  always @(posedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      done_in = -1; m_started = 0; m_mode = 0; m_ovf = 0;
      e_dot = '0; e_doten = 0; e_last = 0; e_cnt = '0; e_ful0 = 0; e_ful1 = 0;
    end else begin
      sel = -1;
      olast = 0;
      rec = '0;
      if (!bus.IN_FULL) begin
        if (done_in < 0) begin
          if (q0.size() > 0 && q1.size() > 0) begin
            if (m_mode) sel = (q1[0][KEYW-1:0] > q0[0][KEYW-1:0]) ? 1 : 0;
            else        sel = (q1[0][KEYW-1:0] < q0[0][KEYW-1:0]) ? 1 : 0;
          end
        end else if (done_in == 1) begin
          if (q0.size() > 0) sel = 0;
        end else begin
          if (q1.size() > 0) sel = 1;
        end
      end
      if (sel == 0) rec = q0.pop_front();
      if (sel == 1) rec = q1.pop_front();
      if (sel >= 0) begin
        if (done_in < 0) begin
          if (rec[DATW]) done_in = sel;
        end else if (rec[DATW]) begin
          olast = 1;
          done_in = -1;
        end
      end
      if (!m_started && sel < 0) m_mode = bus.MODE;
      if (sel >= 0) m_started = !olast;
      if (e_doten && e_last) e_cnt = '0;
      if (sel >= 0) begin
        e_cnt = e_cnt + 1;
        e_dot = rec[DATW-1:0];
        m_log.push_back({olast, rec[DATW-1:0]});
      end
      e_doten = (sel >= 0);
      e_last  = olast;
      if (bus.DIN0EN) begin
        if (q0.size() < D) q0.push_back({bus.DIN0LAST, bus.DIN0});
        else m_ovf = 1;
      end
      if (bus.DIN1EN) begin
        if (q1.size() < D) q1.push_back({bus.DIN1LAST, bus.DIN1});
        else m_ovf = 1;
      end
      e_ful0 = (q0.size() >= D - 1);
      e_ful1 = (q1.size() >= D - 1);
    end
    #1;
    chk("doten",   64'(bus.DOTEN),   64'(e_doten));
    chk("dotlast", 64'(bus.DOTLAST), 64'(e_last));
    chk("dot",     bus.DOT,          e_dot);
    chk("cnt",     64'(bus.CNT),     64'(e_cnt));
    chk("ful0",    64'(bus.FUL0),    64'(e_ful0));
    chk("ful1",    64'(bus.FUL1),    64'(e_ful1));
    chk("ovf",     64'(bus.OVF),     64'(m_ovf));
    if (bus.DOTEN) begin
      dut_log.push_back({bus.DOTLAST, bus.DOT});
      dut_cnt.push_back(int'(bus.CNT));
    end
  end

  logic [63:0] ek [8];
  int          ec [8];
  logic [7:0]  el;

  task automatic clr();
    dut_log.delete();
    m_log.delete();
    dut_cnt.delete();
  endtask

  task automatic chk_seq(input string nm, input int n);
    chk({nm, " len"},  64'(dut_log.size()), 64'(n));
    chk({nm, " mlen"}, 64'(m_log.size()),   64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < dut_log.size()) begin
        chk($sformatf("%s rec%0d", nm, i),  dut_log[i][63:0],   ek[i]);
        chk($sformatf("%s last%0d", nm, i), 64'(dut_log[i][64]), 64'(el[i]));
        chk($sformatf("%s cnt%0d", nm, i),  64'(dut_cnt[i]),     64'(ec[i]));
      end
      if (i < m_log.size()) begin
        chk($sformatf("%s model rec%0d", nm, i), m_log[i][63:0], ek[i]);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put2(input bit e0, input logic [63:0] d0, input bit l0,
                      input bit e1, input logic [63:0] d1, input bit l1);
    bus.DIN0EN = e0; bus.DIN0 = d0; bus.DIN0LAST = l0;
    bus.DIN1EN = e1; bus.DIN1 = d1; bus.DIN1LAST = l1;
    @(negedge clk);
    bus.DIN0EN = 1'b0;
    bus.DIN1EN = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time limit reached before finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit e0, e1;
    rst_n = 1'b0;
    bus.MODE = 1'b0; bus.IN_FULL = 1'b0;
    bus.DIN0 = '0; bus.DIN1 = '0;
    bus.DIN0EN = 1'b0; bus.DIN1EN = 1'b0; bus.DIN0LAST = 1'b0; bus.DIN1LAST = 1'b0;
    #2;
    chk("rst doten", 64'(bus.DOTEN), 64'd0);
    chk("rst dot",   bus.DOT,        64'd0);
    chk("rst cnt",   64'(bus.CNT),   64'd0);
    chk("rst ful0",  64'(bus.FUL0),  64'd0);
    chk("rst ovf",   64'(bus.OVF),   64'd0);
    tick(2);
    rst_n = 1'b1;

    // ascending merge
    clr();
    bus.IN_FULL = 1'b1;
    put2(1, 64'd1, 0, 1, 64'd2, 0);
    put2(1, 64'd3, 0, 1, 64'd4, 0);
    put2(1, 64'd5, 1, 1, 64'd6, 1);
    bus.IN_FULL = 1'b0;
    tick(10);
    ek = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd0, 64'd0};
    ec = '{1, 2, 3, 4, 5, 6, 0, 0};
    el = 8'b0010_0000;
    chk_seq("asc", 6);
    chk("asc cnt end", 64'(bus.CNT), 64'd0);

    // descending merge, MODE toggled after first output
    clr();
    bus.MODE = 1'b1;
    bus.IN_FULL = 1'b1;
    put2(1, 64'd9, 0, 1, 64'd8, 0);
    put2(1, 64'd5, 1, 1, 64'd7, 0);
    put2(0, 64'd0, 0, 1, 64'd1, 1);
    bus.IN_FULL = 1'b0;
    tick(1);
    bus.MODE = 1'b0;
    tick(8);
    ek = '{64'd9, 64'd8, 64'd7, 64'd5, 64'd1, 64'd0, 64'd0, 64'd0};
    ec = '{1, 2, 3, 4, 5, 0, 0, 0};
    el = 8'b0001_0000;
    chk_seq("desc", 5);

    // tie on key: input 0 first
    clr();
    put2(1, 64'h0000_000A_0000_0004, 1, 1, 64'h0000_000B_0000_0004, 1);
    tick(5);
    ek = '{64'h0000_000A_0000_0004, 64'h0000_000B_0000_0004, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
    ec = '{1, 2, 0, 0, 0, 0, 0, 0};
    el = 8'b0000_0010;
    chk_seq("tie", 2);

    // next-run isolation
    clr();
    bus.IN_FULL = 1'b1;
    put2(1, 64'd2, 1, 1, 64'd3, 0);
    put2(1, 64'd10, 0, 1, 64'd4, 1);
    put2(1, 64'd12, 1, 0, 64'd0, 0);
    bus.IN_FULL = 1'b0;
    tick(6);
    chk("iso cnt gap", 64'(bus.CNT), 64'd0);
    put2(0, 64'd0, 0, 1, 64'd11, 0);
    put2(0, 64'd0, 0, 1, 64'd13, 1);
    tick(6);
    ek = '{64'd2, 64'd3, 64'd4, 64'd10, 64'd11, 64'd12, 64'd13, 64'd0};
    ec = '{1, 2, 3, 1, 2, 3, 4, 0};
    el = 8'b0100_0100;
    chk_seq("iso", 7);

    // asynchronous reset with buffered records
    bus.IN_FULL = 1'b1;
    put2(1, 64'd20, 0, 0, 64'd0, 0);
    put2(1, 64'd21, 0, 0, 64'd0, 0);
    put2(1, 64'd22, 0, 0, 64'd0, 0);
    chk("pre-rst ful0", 64'(bus.FUL0), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid-rst doten",   64'(bus.DOTEN),   64'd0);
    chk("mid-rst dotlast", 64'(bus.DOTLAST), 64'd0);
    chk("mid-rst cnt",     64'(bus.CNT),     64'd0);
    chk("mid-rst ful0",    64'(bus.FUL0),    64'd0);
    chk("mid-rst ful1",    64'(bus.FUL1),    64'd0);
    tick(2);
    rst_n = 1'b1;
    clr();
    bus.IN_FULL = 1'b0;
    put2(1, 64'd1, 0, 1, 64'd3, 1);
    put2(1, 64'd2, 1, 0, 64'd0, 0);
    tick(6);
    ek = '{64'd1, 64'd2, 64'd3, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
    ec = '{1, 2, 3, 0, 0, 0, 0, 0};
    el = 8'b0000_0100;
    chk_seq("rst", 3);

    // back-pressure, almost-full and overflow
    clr();
    put2(1, 64'd10, 0, 1, 64'd50, 1);
    tick(1);
    bus.IN_FULL = 1'b1;
    put2(1, 64'd11, 0, 0, 64'd0, 0);
    put2(1, 64'd12, 0, 0, 64'd0, 0);
    chk("bp ful0 at 2", 64'(bus.FUL0), 64'd0);
    put2(1, 64'd13, 0, 0, 64'd0, 0);
    chk("bp ful0 at 3", 64'(bus.FUL0), 64'd1);
    chk("bp doten hold", 64'(bus.DOTEN), 64'd0);
    put2(1, 64'd14, 0, 0, 64'd0, 0);
    chk("bp ovf before", 64'(bus.OVF), 64'd0);
    put2(1, 64'd15, 0, 0, 64'd0, 0);
    chk("bp ovf after", 64'(bus.OVF), 64'd1);
    bus.IN_FULL = 1'b0;
    tick(5);
    put2(1, 64'd16, 1, 0, 64'd0, 0);
    tick(5);
    ek = '{64'd10, 64'd11, 64'd12, 64'd13, 64'd14, 64'd16, 64'd50, 64'd0};
    ec = '{1, 2, 3, 4, 5, 6, 7, 0};
    el = 8'b0100_0000;
    chk_seq("bp", 7);

    // randomized traffic
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      bus.IN_FULL = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 63) == 0) bus.MODE = ~bus.MODE;
      e0 = (!bus.FUL0 && $urandom_range(0, 1) == 1) || ($urandom_range(0, 40) == 0);
      e1 = (!bus.FUL1 && $urandom_range(0, 1) == 1) || ($urandom_range(0, 40) == 0);
      bus.DIN0EN = e0; bus.DIN0 = {$urandom(), 32'($urandom_range(0, 20))};
      bus.DIN0LAST = ($urandom_range(0, 3) == 0);
      bus.DIN1EN = e1; bus.DIN1 = {$urandom(), 32'($urandom_range(0, 20))};
      bus.DIN1LAST = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    bus.DIN0EN = 1'b0;
    bus.DIN1EN = 1'b0;
    bus.IN_FULL = 1'b0;
    tick(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
